// File: rtl/img_src_tx.sv
// img_src_tx: source-side transmitter for one arbiter slave port.
// Fetches cmd_len words from pixel memory through a 2-entry prefetch FIFO
// and streams them to the arbiter with a valid/ready handshake.
module img_src_tx #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic [1:0]    cmd_mode,
  input  logic [AW-1:0] cmd_base,
  input  logic [LW-1:0] cmd_len,
  output logic          busy,
  output logic          done,
  output logic          cmd_err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [1:0]    slv_mode,
  output logic          slv_data_valid,
  output logic [DW-1:0] slv_data,
  output logic          slv_proc_valid,
  input  logic          slv_ready,
  input  logic          mstr_cmplt
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_CMPLT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] fetched;
  logic [LW-1:0] sent;
  logic [DW-1:0] fifo_mem [2];
  logic          rp, wp;
  logic [1:0]    occ;
  logic          rd_pend;

  logic          cmd_ok;
  logic          head_valid;
  logic          xfer;
  logic          last_word;
  logic [2:0]    fill;
  logic          fetch_ok;

  assign cmd_ok     = (cmd_mode != 2'd0) && (cmd_len != '0);
  assign head_valid = (state_q == STREAM) && (occ != 2'd0);
  assign xfer       = head_valid && slv_ready;
  assign last_word  = (sent == len_q - LW'(1));
  // Occupancy counts a word leaving this cycle as already gone, so a new
  // read can be issued every cycle while the arbiter keeps accepting.
  assign fill       = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, xfer};
  assign fetch_ok   = (state_q == STREAM) && (fetched < len_q) && (fill < 3'd2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (cmd_start && cmd_ok) state_d = STREAM;
      STREAM:     if (xfer && last_word)   state_d = WAIT_CMPLT;
      WAIT_CMPLT: if (mstr_cmplt)          state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and FIFO head
  always_comb begin
    busy           = (state_q != IDLE);
    rd_en          = fetch_ok;
    rd_addr        = fetch_ok ? (base_q + fetched[AW-1:0]) : '0;
    slv_mode       = (state_q == STREAM) ? mode_q : 2'd0;
    slv_data_valid = head_valid;
    slv_data       = head_valid ? fifo_mem[rp] : '0;
    slv_proc_valid = head_valid && last_word;
  end

  // Job registers, prefetch FIFO, counters and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      fetched     <= '0;
      sent        <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rp          <= 1'b0;
      wp          <= 1'b0;
      occ         <= '0;
      rd_pend     <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      done    <= (state_q == WAIT_CMPLT) && mstr_cmplt;
      cmd_err <= (state_q == IDLE) && cmd_start && !cmd_ok;
      if ((state_q == IDLE) && cmd_start && cmd_ok) begin
        mode_q  <= cmd_mode;
        base_q  <= cmd_base;
        len_q   <= cmd_len;
        fetched <= '0;
        sent    <= '0;
        rp      <= 1'b0;
        wp      <= 1'b0;
        occ     <= '0;
        rd_pend <= 1'b0;
      end else if (state_q == STREAM) begin
        rd_pend <= fetch_ok;
        if (fetch_ok) fetched <= fetched + LW'(1);
        if (rd_pend) begin
          fifo_mem[wp] <= rd_data;
          wp           <= ~wp;
        end
        if (xfer) begin
          rp   <= ~rp;
          sent <= sent + LW'(1);
        end
        occ <= occ + {1'b0, rd_pend} - {1'b0, xfer};
      end
    end
  end

endmodule

// File: tb/tb_img_src_tx.sv
// tb_img_src_tx: directed bench for img_src_tx with a registered pixel RAM model.
module tb_img_src_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [1:0]  cmd_mode;
  logic [11:0] cmd_base;
  logic [15:0] cmd_len;
  logic        busy, done, cmd_err, rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  slv_mode;
  logic        slv_data_valid;
  logic [31:0] slv_data;
  logic        slv_proc_valid;
  logic        slv_ready;
  logic        mstr_cmplt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:4095];

  logic [31:0] q_data [$];
  logic        q_proc [$];
  int          q_idx  [$];
  logic [11:0] q_addr [$];
  int          stab_err, status_err, first_valid;
  logic        done_seen, err_seen, timed_out;

  img_src_tx #(.DW(32), .AW(12), .LW(16)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .busy(busy), .done(done),
    .cmd_err(cmd_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .slv_mode(slv_mode), .slv_data_valid(slv_data_valid), .slv_data(slv_data),
    .slv_proc_valid(slv_proc_valid), .slv_ready(slv_ready), .mstr_cmplt(mstr_cmplt)
  );

  always #5 clk = ~clk;

  // Pixel RAM: data returns one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    if (a >= 12'h010 && a < 12'h014) return 32'h0000_00A0 + {20'b0, a - 12'h010};
    return 32'h5A00_0000 | {20'b0, a};
  endfunction

  task automatic start_cmd(input logic [1:0] m, input logic [11:0] b, input logic [15:0] l);
    @(negedge clk);
    cmd_mode  = m;
    cmd_base  = b;
    cmd_len   = l;
    cmd_start = 1'b1;
  endtask

  // Runs the handshake after a start_cmd; pat 0 = ready held high, pat 1 = 1,0,0 repeating.
  // inj: loop index to pulse a stray cmd_start, cmpl_at: index to pulse an early mstr_cmplt.
  task automatic stream(input int len, input int pat, input logic [1:0] m, input int inj, input int cmpl_at);
    int k = 0;
    int nx = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pp = 1'b0;
    logic [31:0] pd = '0;
    q_data.delete(); q_proc.delete(); q_idx.delete(); q_addr.delete();
    stab_err = 0; status_err = 0; first_valid = -1;
    done_seen = 1'b0; err_seen = 1'b0; timed_out = 1'b0;
    while (nx < len && k < 400) begin
      @(negedge clk);
      cmd_start  = (k == inj);
      if (k == inj) cmd_base = 12'h800;
      mstr_cmplt = (k == cmpl_at);
      if (done)    done_seen = 1'b1;
      if (cmd_err) err_seen  = 1'b1;
      if (!busy)   status_err++;
      if (rd_en)   q_addr.push_back(rd_addr);
      if (slv_data_valid && first_valid < 0) first_valid = k;
      if (slv_data_valid && slv_mode !== m) status_err++;
      if (pv && !pr && (slv_data_valid !== 1'b1 || slv_data !== pd || slv_proc_valid !== pp))
        stab_err++;
      pv = slv_data_valid; pd = slv_data; pp = slv_proc_valid;
      slv_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
      pr = slv_ready;
      if (slv_data_valid && slv_ready) begin
        q_data.push_back(slv_data);
        q_proc.push_back(slv_proc_valid);
        q_idx.push_back(k);
        nx++;
      end
      k++;
    end
    if (nx < len) timed_out = 1'b1;
    @(negedge clk);
    slv_ready = 1'b0; mstr_cmplt = 1'b0; cmd_start = 1'b0;
  endtask

  // Checks the WAIT_CMPLT outputs, then closes the job with mstr_cmplt
  task automatic close_job(input string tag);
    n_checks++;
    if ({slv_mode, slv_data_valid, slv_proc_valid, slv_data} !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_outputs: mode=%0d valid=%b proc=%b busy=%b, required 0/0/0 busy=1",
               tag, slv_mode, slv_data_valid, slv_proc_valid, busy);
    end
    mstr_cmplt = 1'b1;
    @(negedge clk);
    mstr_cmplt = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b busy=%b, required done=1 busy=0", tag, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: done=%b, required 0", tag, done);
    end
  endtask

  task automatic check_words(input string tag, input logic [11:0] base, input int len);
    n_checks++;
    if (timed_out || q_data.size() != len) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d words, required %0d", tag, q_data.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        logic [11:0] ea;
        ea = base + 12'(i);
        n_checks++;
        if (q_data[i] !== exp_word(ea) || q_proc[i] !== (i == len - 1)) begin
          n_fail++;
          $display("FAIL %s word%0d: data=%h proc=%b, required data=%h proc=%b",
                   tag, i, q_data[i], q_proc[i], exp_word(ea), (i == len - 1));
        end
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, done, cmd_err, rd_en, rd_addr, slv_mode, slv_data_valid, slv_data, slv_proc_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: outputs busy=%b rd_en=%b valid=%b mode=%0d, required all 0",
               busy, rd_en, slv_data_valid, slv_mode);
    end
    start_cmd(2'd1, 12'h100, 16'd8);
    @(negedge clk);
    cmd_start = 1'b0;
    slv_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, cmd_err, rd_en, rd_addr, slv_mode, slv_data_valid, slv_data, slv_proc_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_stream: busy=%b rd_en=%b valid=%b mode=%0d data=%h, required all 0",
               busy, rd_en, slv_data_valid, slv_mode, slv_data);
    end
    slv_ready = 1'b0;
    rst = 1'b0;
    start_cmd(2'd3, 12'h020, 16'd2);
    stream(2, 0, 2'd3, -1, -1);
    check_words("reset_rerun", 12'h020, 2);
    close_job("reset_rerun");
  endtask

  task automatic test_basic;
    start_cmd(2'd2, 12'h010, 16'd4);
    stream(4, 0, 2'd2, -1, -1);
    n_checks++;
    if (first_valid !== 2) begin
      n_fail++;
      $display("FAIL basic_first_valid: cycle %0d, required 2", first_valid);
    end
    check_words("basic", 12'h010, 4);
    for (int i = 0; i < 4 && i < q_idx.size(); i++) begin
      n_checks++;
      if (q_idx[i] !== 2 + i) begin
        n_fail++;
        $display("FAIL basic_edge%0d: transfer at cycle %0d, required %0d", i, q_idx[i], 2 + i);
      end
    end
    n_checks++;
    if (status_err !== 0) begin
      n_fail++;
      $display("FAIL basic_mode_busy: %0d bad cycles, required 0", status_err);
    end
    close_job("basic");
  endtask

  task automatic test_backpressure;
    start_cmd(2'd1, 12'h200, 16'd6);
    stream(6, 1, 2'd1, -1, -1);
    check_words("backpressure", 12'h200, 6);
    n_checks++;
    if (stab_err !== 0) begin
      n_fail++;
      $display("FAIL backpressure_stable: %0d unstable stalled cycles, required 0", stab_err);
    end
    close_job("backpressure");
  endtask

  task automatic test_wrap;
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    start_cmd(2'd2, 12'hFFE, 16'd4);
    stream(4, 0, 2'd2, -1, -1);
    n_checks++;
    if (q_addr.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_reads: %0d reads, required 4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_addr[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d: rd_addr=%h, required %h", i, q_addr[i], exp_a[i]);
        end
      end
    end
    check_words("wrap", 12'hFFE, 4);
    close_job("wrap");
  endtask

  task automatic test_errors;
    start_cmd(2'd1, 12'h000, 16'd0);
    @(negedge clk);
    cmd_start = 1'b0;
    n_checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_len0: cmd_err=%b busy=%b, required 1/0", cmd_err, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_len0_width: cmd_err=%b busy=%b, required 0/0", cmd_err, busy);
    end
    start_cmd(2'd0, 12'h000, 16'd5);
    @(negedge clk);
    cmd_start = 1'b0;
    n_checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_mode0: cmd_err=%b busy=%b, required 1/0", cmd_err, busy);
    end
    start_cmd(2'd3, 12'h300, 16'd6);
    stream(6, 1, 2'd3, 4, 3);
    n_checks++;
    if (err_seen !== 1'b0 || done_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL err_ignored: cmd_err seen=%b done seen=%b, required 0/0", err_seen, done_seen);
    end
    check_words("err_stray_cmd", 12'h300, 6);
    close_job("err_stray_cmd");
  endtask

  task automatic test_len1;
    start_cmd(2'd1, 12'h013, 16'd1);
    stream(1, 0, 2'd1, -1, -1);
    check_words("len1", 12'h013, 1);
    cmd_mode = 2'd2; cmd_base = 12'h010; cmd_len = 16'd2; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || cmd_err !== 1'b0 || slv_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL len1_cmd_in_wait: busy=%b cmd_err=%b mode=%0d, required 1/0/0", busy, cmd_err, slv_mode);
    end
    close_job("len1");
    start_cmd(2'd2, 12'h010, 16'd1);
    stream(1, 0, 2'd2, -1, -1);
    n_checks++;
    if (status_err !== 0) begin
      n_fail++;
      $display("FAIL len1_next_busy: %0d bad cycles, required 0", status_err);
    end
    check_words("len1_next", 12'h010, 1);
    close_job("len1_next");
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'h5A00_0000 | a;
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 32'h0000_00A0 + i;
    rst = 1'b1; cmd_start = 1'b0; cmd_mode = '0; cmd_base = '0; cmd_len = '0;
    slv_ready = 1'b0; mstr_cmplt = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    test_reset_entry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic test_reset_entry;
    // The first comparison looks at the outputs while reset is still held.
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_errors();
    test_len1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
